// File: rtl/pipelined_rv_core_p.sv
// pipelined_rv_core_p: 3-stage (fetch / execute / writeback) RV32I-subset core with run/halt control
// Optional feature: define MUL_EN to enable R-type MUL (funct7 0000001, funct3 000).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   pm_wr_en/pm_byte_in/pm_addr  byte-serial program load (accepted in IDLE/HALT only)
//   start               begin execution at pc 0
//   busy, halted        RUN / HALT state flags
//   pc                  current fetch word address
//   alu_result, result_valid  writeback-stage result and its valid flag
module pipelined_rv_core_p #(
  parameter int DATA_WIDTH = 8,
  parameter int REG_DEPTH  = 32,
  parameter int PM_DEPTH   = 32,
  parameter int PM_AW      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pm_wr_en,
  input  logic [7:0]            pm_byte_in,
  input  logic [PM_AW+1:0]      pm_addr,
  input  logic                  start,
  output logic                  busy,
  output logic                  halted,
  output logic [PM_AW-1:0]      pc,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  result_valid
);
  localparam int SW  = $clog2(DATA_WIDTH);
  localparam int RAW = $clog2(REG_DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;
  state_t r_state, w_next;
  logic [31:0]           r_pm [PM_DEPTH];
  logic [31:0]           r_ir;
  logic                  r_ir_valid;
  logic [PM_AW-1:0]      r_pc;
  logic [DATA_WIDTH-1:0] r_rf [REG_DEPTH];
  logic                  r_w_valid;
  logic [4:0]            r_w_rd;
  logic [DATA_WIDTH-1:0] r_w_result;
  logic [6:0]            w_opc, w_f7;
  logic [4:0]            w_rd, w_rs1, w_rs2;
  logic [2:0]            w_f3;
  logic                  w_is_r, w_is_i, w_f7_0, w_f7_20, w_halt, w_ok, w_exec;
  logic [DATA_WIDTH-1:0] w_imm, w_op1, w_src2, w_op2, w_res, w_mul;
  logic [SW-1:0]         w_sh;
  assign w_opc   = r_ir[6:0];
  assign w_rd    = r_ir[11:7];
  assign w_f3    = r_ir[14:12];
  assign w_rs1   = r_ir[19:15];
  assign w_rs2   = r_ir[24:20];
  assign w_f7    = r_ir[31:25];
  assign w_is_r  = w_opc == 7'b0110011;
  assign w_is_i  = w_opc == 7'b0010011;
  assign w_f7_0  = w_f7 == 7'b0000000;
  assign w_f7_20 = w_f7 == 7'b0100000;
  assign w_halt  = r_state == S_RUN && r_ir_valid && r_ir == 32'd0;
  // Signed cast sign-extends when DATA_WIDTH > 12 and truncates otherwise.
  assign w_imm   = DATA_WIDTH'($signed(r_ir[31:20]));
  // Register read with writeback forwarding; out-of-range indices read as 0.
  function automatic logic [DATA_WIDTH-1:0] rd_reg(input logic [4:0] a);
    if (a == 5'd0 || int'(a) >= REG_DEPTH) return '0;
    if (r_w_valid && r_w_rd == a) return r_w_result;
    return r_rf[a[RAW-1:0]];
  endfunction
  assign w_op1  = rd_reg(w_rs1);
  assign w_src2 = rd_reg(w_rs2);
  assign w_op2  = w_is_i ? w_imm : w_src2;
  assign w_sh   = w_op2[SW-1:0];
  assign w_mul  = w_op1 * w_op2;
  always_comb begin
    w_ok  = 1'b0;
    w_res = '0;
    case (w_f3)
      3'b000: begin
        w_ok  = w_is_i || (w_is_r && (w_f7_0 || w_f7_20));
        w_res = (w_is_r && w_f7_20) ? w_op1 - w_op2 : w_op1 + w_op2;
`ifdef MUL_EN
        if (w_is_r && w_f7 == 7'b0000001) begin
          w_ok  = 1'b1;
          w_res = w_mul;
        end
`endif
      end
      3'b111: begin
        w_ok  = w_is_i || (w_is_r && w_f7_0);
        w_res = w_op1 & w_op2;
      end
      3'b110: begin
        w_ok  = w_is_i || (w_is_r && w_f7_0);
        w_res = w_op1 | w_op2;
      end
      3'b100: begin
        w_ok  = w_is_i || (w_is_r && w_f7_0);
        w_res = w_op1 ^ w_op2;
      end
      3'b010: begin
        w_ok  = w_is_i || (w_is_r && w_f7_0);
        w_res = DATA_WIDTH'($signed(w_op1) < $signed(w_op2));
      end
      3'b001: begin
        w_ok  = (w_is_i || w_is_r) && w_f7_0;
        w_res = w_op1 << w_sh;
      end
      3'b101: begin
        w_ok  = (w_is_i || w_is_r) && (w_f7_0 || w_f7_20);
        w_res = w_f7_20 ? $unsigned($signed(w_op1) >>> w_sh) : w_op1 >> w_sh;
      end
      default: w_ok = 1'b0;
    endcase
  end
`ifndef MUL_EN
  logic w_unused_mul;
  assign w_unused_mul = ^w_mul;
`endif
  assign w_exec = r_ir_valid && w_ok;
  always_comb begin
    w_next = r_state;
    w_next = r_state == S_RUN ? (w_halt ? S_HALT : S_RUN) : (start ? S_RUN : r_state);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  // Program memory survives reset, so it has no reset branch.
  always_ff @(posedge clk)
    if (pm_wr_en && r_state != S_RUN) r_pm[pm_addr[PM_AW+1:2]][{pm_addr[1:0], 3'b000} +: 8] <= pm_byte_in;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= '0;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
      r_w_valid  <= 1'b0;
      r_w_rd     <= '0;
      r_w_result <= '0;
    end else if (r_state != S_RUN) begin
      r_ir_valid <= 1'b0;
      r_w_valid  <= 1'b0;
      if (start) r_pc <= '0;
    end else if (w_halt) begin
      r_ir_valid <= 1'b0;
      r_w_valid  <= 1'b0;
    end else begin
      r_ir       <= r_pm[r_pc];
      r_ir_valid <= 1'b1;
      r_pc       <= r_pc + 1'b1;
      r_w_valid  <= w_exec;
      if (w_exec) begin
        r_w_rd     <= w_rd;
        r_w_result <= w_res;
      end
    end
  end
  // The instruction in W writes back on every edge it is valid, including the halt edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_DEPTH; i++) r_rf[i] <= '0;
    end else if (r_w_valid && r_w_rd != 5'd0 && int'(r_w_rd) < REG_DEPTH) begin
      r_rf[r_w_rd[RAW-1:0]] <= r_w_result;
    end
  end
  assign busy         = r_state == S_RUN;
  assign halted       = r_state == S_HALT;
  assign pc           = r_pc;
  assign alu_result   = r_w_result;
  assign result_valid = r_w_valid;
endmodule

// File: tb/tb_pipelined_rv_core_p.sv
// tb_pipelined_rv_core_p: scoreboard bench with an instruction-level reference model
module tb_pipelined_rv_core_p;
  localparam int DW  = 8;
  localparam int PMD = 32;
  localparam int AW  = 5;
  localparam int MASK = (1 << DW) - 1;
`ifdef MUL_EN
  localparam bit MULEN = 1'b1;
`else
  localparam bit MULEN = 1'b0;
`endif
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pm_wr_en = 1'b0;
  logic [7:0]    pm_byte_in = '0;
  logic [AW+1:0] pm_addr = '0;
  logic          start = 1'b0;
  logic          busy, halted, result_valid;
  logic [AW-1:0] pc;
  logic [DW-1:0] alu_result;
  int            n_checks = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q[$];
  logic [31:0]   prog[PMD];
  int            m_rf[32];

  pipelined_rv_core_p #(.DATA_WIDTH(DW), .REG_DEPTH(32), .PM_DEPTH(PMD), .PM_AW(AW)) dut (
    .clk(clk), .rst(rst), .pm_wr_en(pm_wr_en), .pm_byte_in(pm_byte_in), .pm_addr(pm_addr),
    .start(start), .busy(busy), .halted(halted), .pc(pc), .alu_result(alu_result),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every retired result must match the next expected value in order.
  always @(negedge clk) begin
    if (rst === 1'b0 && result_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_result: got %0h, expected no result", alu_result);
      end else begin
        chk("result", alu_result, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], 7'h13};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7;
    int k, s;
    k = $urandom_range(0, 9);
    s = $urandom_range(0, 3);
    rd = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3 = 3'($urandom);
    f7 = s == 0 ? 7'h00 : s == 1 ? 7'h20 : s == 2 ? 7'h01 : 7'($urandom);
    if (k < 5) return {f7, rs2, rs1, f3, rd, 7'h33};
    if (k < 9) return {f7, rs2, rs1, f3, rd, 7'h13};
    return {f7, rs2, rs1, f3, rd, 7'h03};
  endfunction

  // Architectural execution of one instruction on the model register file.
  function automatic void model_exec(input logic [31:0] w, output bit v, output int res);
    int opc, rd, f3, rs1, rs2, f7, imm, a, b, sa, sb, sh;
    bit is_r, is_i;
    opc = int'(w[6:0]);
    rd = int'(w[11:7]);
    f3 = int'(w[14:12]);
    rs1 = int'(w[19:15]);
    rs2 = int'(w[24:20]);
    f7 = int'(w[31:25]);
    imm = int'($signed(w[31:20]));
    is_r = opc == 'h33;
    is_i = opc == 'h13;
    a = m_rf[rs1];
    b = is_i ? (imm & MASK) : m_rf[rs2];
    sa = a >= (1 << (DW - 1)) ? a - (1 << DW) : a;
    sb = b >= (1 << (DW - 1)) ? b - (1 << DW) : b;
    sh = b % DW;
    v = 1'b0;
    res = 0;
    case (f3)
      0: begin
        v = is_i || (is_r && (f7 == 0 || f7 == 32 || (MULEN && f7 == 1)));
        res = (is_r && f7 == 32) ? a - b : (is_r && f7 == 1) ? a * b : a + b;
      end
      7: begin v = is_i || (is_r && f7 == 0); res = a & b; end
      6: begin v = is_i || (is_r && f7 == 0); res = a | b; end
      4: begin v = is_i || (is_r && f7 == 0); res = a ^ b; end
      2: begin v = is_i || (is_r && f7 == 0); res = sa < sb ? 1 : 0; end
      1: begin v = (is_i || is_r) && f7 == 0; res = a << sh; end
      5: begin v = (is_i || is_r) && (f7 == 0 || f7 == 32); res = f7 == 32 ? sa >>> sh : a >> sh; end
      default: v = 1'b0;
    endcase
    res = res & MASK;
    if (v && rd != 0) m_rf[rd] = res;
  endfunction

  task automatic model_run(input int limit);
    bit v;
    int r;
    for (int i = 0; i < limit; i++) begin
      if (prog[i % PMD] == 32'd0) break;
      model_exec(prog[i % PMD], v, r);
      if (v) exp_q.push_back(DW'(r));
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_result", alu_result, 0);
    step();
    rst = 1'b0;
    foreach (m_rf[i]) m_rf[i] = 0;
  endtask

  // Loads every word, word 0 last and its opcode byte last, optionally starting on that same edge.
  task automatic load(input bit go);
    for (int w = PMD - 1; w >= 0; w--) begin
      for (int l = 3; l >= 0; l--) begin
        pm_wr_en = 1'b1;
        pm_addr = {w[AW-1:0], l[1:0]};
        pm_byte_in = prog[w][8*l +: 8];
        start = go && w == 0 && l == 0;
        step();
      end
    end
    pm_wr_en = 1'b0;
    start = 1'b0;
  endtask

  task automatic start_prog(input int limit);
    do_reset();
    model_run(limit);
    load(1'b1);
  endtask

  task automatic finish_prog(input int len);
    int c;
    logic [AW-1:0] pc_exp;
    c = 0;
    pc_exp = AW'(len + 1);
    while (halted !== 1'b1 && c < 200) begin
      step();
      c++;
    end
    chk("halt_reached", halted, 1);
    chk("halt_busy", busy, 0);
    chk("halt_pc", pc, pc_exp);
    step();
    step();
    chk("halt_pc_hold", pc, pc_exp);
    chk("halt_valid", result_valid, 0);
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic restart(input int len);
    model_run(PMD);
    start = 1'b1;
    step();
    start = 1'b0;
    finish_prog(len);
  endtask

  task automatic clear_prog();
    foreach (prog[i]) prog[i] = 32'd0;
  endtask

  initial begin
    int len;
    #3;
    // Directed: basic program with exact latency and forwarding.
    clear_prog();
    prog[0] = enc_i(5, 0, 0, 1);
    prog[1] = enc_i(3, 0, 0, 2);
    prog[2] = enc_r(0, 2, 1, 0, 3);
    start_prog(PMD);
    chk("t1_busy", busy, 1);
    step();
    step();
    chk("t1_v0", result_valid, 1);
    chk("t1_r0", alu_result, 5);
    step();
    chk("t1_r1", alu_result, 3);
    step();
    chk("t1_r2", alu_result, 8);
    finish_prog(3);
    // Wrap, subtract, arithmetic/logical shifts, signed compare.
    clear_prog();
    prog[0] = enc_i(-1, 0, 0, 1);
    prog[1] = enc_i(2, 1, 0, 1);
    prog[2] = enc_r(32, 1, 0, 0, 2);
    prog[3] = enc_i('h404, 2, 5, 3);
    prog[4] = enc_i(4, 2, 5, 4);
    prog[5] = enc_r(0, 0, 2, 2, 5);
    start_prog(PMD);
    finish_prog(6);
    // x0 writes are shown but discarded.
    clear_prog();
    prog[0] = enc_i(7, 0, 0, 0);
    prog[1] = enc_r(0, 0, 0, 0, 1);
    start_prog(PMD);
    finish_prog(2);
    // MUL encoding (NOP unless enabled), followed by a read of x2.
    clear_prog();
    prog[0] = enc_i(12, 0, 0, 1);
    prog[1] = enc_r(1, 1, 1, 0, 2);
    prog[2] = enc_r(0, 0, 2, 0, 3);
    start_prog(PMD);
    finish_prog(3);
    // Async reset mid-run, then replay from retained memory.
    clear_prog();
    prog[0] = enc_i(5, 0, 0, 1);
    prog[1] = enc_i(3, 0, 0, 2);
    prog[2] = enc_r(0, 2, 1, 0, 3);
    start_prog(PMD);
    step();
    step();
    chk("t5_pre_valid", result_valid, 1);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_valid", result_valid, 0);
    chk("t5_result", alu_result, 0);
    chk("t5_pc", pc, 0);
    step();
    rst = 1'b0;
    foreach (m_rf[i]) m_rf[i] = 0;
    restart(3);
    // Wrap-around with no halt word and an ignored write during RUN.
    foreach (prog[i]) prog[i] = enc_i(1, 1, 0, 1);
    start_prog(200);
    for (int i = 0; i < 31; i++) step();
    chk("t4_pc31", pc, 31);
    step();
    chk("t4_pc_wrap", pc, 0);
    pm_wr_en = 1'b1;
    pm_addr = {5'd5, 2'd0};
    pm_byte_in = 8'h00;
    step();
    pm_wr_en = 1'b0;
    for (int i = 0; i < 40; i++) step();
    chk("t4_busy", busy, 1);
    // Randomized programs, each also rerun from HALT without reset.
    for (int t = 0; t < 8; t++) begin
      clear_prog();
      len = $urandom_range(4, 20);
      for (int i = 0; i < len; i++) prog[i] = rand_instr();
      start_prog(PMD);
      finish_prog(len);
      restart(len);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
